// File: rtl/matmul_apb_master_ctrl.sv
// Purpose: single-outstanding APB master that turns cmd_* requests into SETUP/ACCESS transfers.
// Latency: command accepted at edge k -> SETUP cycle k+1, ACCESS from k+2, rsp_valid cycle k+3 with no wait states.
// Backpressure: cmd_ready low outside IDLE; pready stretches ACCESS up to TIMEOUT cycles; rsp side has none.
module matmul_apb_master_ctrl #(
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_DIM    = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [BUS_WIDTH-1:0]  cmd_wdata,
  input  logic [MAX_DIM-1:0]    cmd_strb,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [BUS_WIDTH-1:0]  pwdata,
  output logic [MAX_DIM-1:0]    pstrb,
  input  logic                  pready,
  input  logic                  pslverr,
  input  logic [BUS_WIDTH-1:0]  prdata,
  output logic                  rsp_valid,
  output logic [BUS_WIDTH-1:0]  rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [15:0]           txn_count,
  output logic [7:0]            err_count
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  // Wait counter value on the last permitted ACCESS cycle with pready low.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     next_state;
  logic       accept;
  logic       complete;
  logic       abort;
  logic [7:0] wait_cnt;

  // Next-state decode plus one-cycle event strobes for accept/complete/abort.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept     = 1'b1;
          next_state = SETUP;
        end
      end
      SETUP: next_state = ACCESS;
      ACCESS: begin
        // pready wins over an expiring counter: a late ready still completes.
        if (pready) begin
          complete   = 1'b1;
          next_state = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          abort      = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register with registered copies of the state-derived outputs,
  // so psel/penable/cmd_ready come straight from flops.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      state     <= next_state;
      psel      <= (next_state != IDLE);
      penable   <= (next_state == ACCESS);
      cmd_ready <= (next_state == IDLE);
    end
  end

  // Capture the command on acceptance; reads present zero data and strobes.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
      pstrb  <= '0;
    end else if (accept) begin
      pwrite <= cmd_write;
      paddr  <= cmd_addr;
      pwdata <= cmd_write ? cmd_wdata : '0;
      pstrb  <= cmd_write ? cmd_strb : '0;
    end
  end

  // Count ACCESS cycles spent waiting on pready; restart for every transfer.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 8'd0;
    end else if (state == SETUP) begin
      wait_cnt <= 8'd0;
    end else if (state == ACCESS && !pready) begin
      wait_cnt <= 8'(wait_cnt + 8'd1);
    end
  end

  // Response pulse; payload fields hold until the next completion or abort.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= complete | abort;
      if (complete) begin
        rsp_err     <= pslverr;
        rsp_timeout <= 1'b0;
        rsp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
      end else if (abort) begin
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
        rsp_rdata   <= '0;
      end
    end
  end

  // Transfer counter wraps; error counter saturates.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count <= 16'd0;
      err_count <= 8'd0;
    end else begin
      if (complete || abort) begin
        txn_count <= 16'(txn_count + 16'd1);
      end
      if (((complete && pslverr) || abort) && (err_count != 8'hFF)) begin
        err_count <= 8'(err_count + 8'd1);
      end
    end
  end

endmodule
